// File: rtl/rvfi_causal_sequencer.sv
// Sequencer that fires the RVFI causal checker's `check` input once, on the
// retirement beat of the target instruction, after a minimum history window.
module rvfi_causal_sequencer #(
    parameter int unsigned NRET        = 1,
    parameter int unsigned CHANNEL_IDX = 0,
    parameter int unsigned MIN_HISTORY = 4,
    parameter int unsigned MAX_WAIT    = 63
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [64*NRET-1:0]   rvfi_order,
    input  logic [5*NRET-1:0]    rvfi_rd_addr,
    input  logic [63:0]          insn_order,
    input  logic [4:0]           register_index,
    output logic                 check,
    output logic                 armed,
    output logic                 done,
    output logic                 timeout,
    output logic [7:0]           younger_cnt,
    output logic [7:0]           wait_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_TIMEOUT
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  younger_cnt_q, younger_cnt_d;

    logic        target_hit;
    logic        history_ok;
    logic        at_limit;
    logic [31:0] younger_inc;
    logic [31:0] younger_sum;

    assign target_hit = rvfi_valid[CHANNEL_IDX]
                     && (rvfi_order[64*CHANNEL_IDX +: 64] == insn_order)
                     && (rvfi_rd_addr[5*CHANNEL_IDX +: 5] == register_index)
                     && (register_index != 5'd0);

    assign history_ok = 32'(wait_cnt_q) >= MIN_HISTORY;
    assign at_limit   = 32'(wait_cnt_q) == MAX_WAIT;

    // Zero-latency on purpose: the checker must see check on the retiring beat.
    assign check = (state_q == S_WAIT) && target_hit && history_ok;

    always_comb begin
        younger_inc = '0;
        for (int c = 0; c < int'(NRET); c++) begin
            if (rvfi_valid[c] && (rvfi_order[64*c +: 64] > insn_order)) begin
                younger_inc = younger_inc + 32'd1;
            end
        end
        younger_sum = 32'(younger_cnt_q) + younger_inc;
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        younger_cnt_d = younger_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d       = S_WAIT;
                    wait_cnt_d    = 8'd0;
                    younger_cnt_d = 8'd0;
                end
            end
            S_WAIT: begin
                wait_cnt_d    = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
                younger_cnt_d = (younger_sum > 32'd255) ? 8'hFF : younger_sum[7:0];
                // check outranks both the early-hit and the watchdog exit.
                if (check) begin
                    state_d = S_DONE;
                end else if (target_hit || at_limit) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= 8'd0;
            younger_cnt_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            younger_cnt_q <= younger_cnt_d;
        end
    end

    assign armed       = (state_q == S_WAIT);
    assign done        = (state_q == S_DONE);
    assign timeout     = (state_q == S_TIMEOUT);
    assign wait_cnt    = wait_cnt_q;
    assign younger_cnt = younger_cnt_q;

endmodule
